instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//  Fetch sequencer between the byte-addressed, combinational-read InstructionMemory and the IF/ID stage.
//  - Owns the PC and drives the memory address.
//  - Buffers fetched words in a small FIFO with a valid/ready handshake to decode.
//  - Applies branch/jump redirects.
//  - Stops on an all-zero word (end of program) or an out-of-range PC.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  MEM_BYTES  1024           instruction memory size in bytes; PC > MEM_BYTES-4 is out of range
//  FQ_DEPTH   2              fetch queue entries (2..4)
// PORTS
//  clk             in   1   single clock, rising edge
//  rst             in   1   asynchronous, active-high reset
//  start           in   1   pulse: leave IDLE and begin fetching at the current PC
//  imem_addr       out  32  byte address to InstructionMemory (always equals pc)
//  imem_rdata      in   32  instruction word, valid in the same cycle as imem_addr
//  if_valid        out  1   queue head holds a valid instruction
//  if_instr        out  32  queue head instruction
//  if_pc           out  32  PC of the queue-head instruction
//  if_ready        in   1   decode accepts the head this cycle
//  redirect_valid  in   1   branch/jal resolved taken
//  redirect_pc     in   32  new fetch target
//  halted          out  1   state HALT and queue empty
//  fetch_fault     out  1   sticky: out-of-range PC or misaligned redirect seen
// BEHAVIOUR
//  Reset (async): pc=RESET_PC; queue empty; state=IDLE; if_valid=0; if_instr=0; if_pc=0; halted=0; fetch_fault=0.
//  States:
//   IDLE -> RUN on start.
//   RUN  -> HALT when the fetched word == 32'h0 or the PC is out of range.
//   HALT -> RUN on redirect_valid.
//   IDLE ignores redirect_valid.
//  RUN fetch slot: fetch occurs when (count<FQ_DEPTH) || (if_valid && if_ready).
//   - Enqueue {imem_rdata, pc}, then pc <= pc+4 (mod 2^32).
//   - Enqueue and dequeue in the same cycle are both performed; count is unchanged.
//  Zero word or out-of-range PC: word NOT enqueued; pc holds; out-of-range also sets fetch_fault. Queue keeps draining.
//  Dequeue: on if_valid && if_ready. Outputs come from registers; head shown the cycle after enqueue (1-cycle fetch latency).
//  Redirect (highest priority, any state except IDLE):
//   - Queue flushed (if_valid=0 next cycle); no enqueue or dequeue that cycle.
//   - pc <= {redirect_pc[31:2],2'b00}; if redirect_pc[1:0]!=0, fetch_fault set.
//   - First redirected instruction reaches if_valid 2 cycles after redirect_valid.
//  start while RUN/HALT: ignored.
//  Reset mid-operation: all state returns to reset values immediately; an in-flight handshake is dropped.
//  if_instr/if_pc hold their last value while if_valid=0.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds two ports, both reset to 0, saturating at 32'hFFFF_FFFF.
//   - perf_fetch_cnt  out 32: count of enqueued instructions.
//   - perf_flush_cnt  out 32: count of valid entries discarded by redirects.
//  FETCH_PERF_EN undefined: both ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset, start, words at 0/4/8 nonzero, if_ready=1
//     -> if_valid 1 cycle after start, if_pc 0,4,8 on successive cycles.
//  2 if_ready=0 for 5 cycles after start, FQ_DEPTH=2
//     -> queue fills with pc 0,4; pc holds at 8; no word lost when ready rises.
//  3 redirect_valid with redirect_pc=32'h40 while queue full
//     -> next cycle if_valid=0; cycle after, if_pc=32'h40; perf_flush_cnt+=2 (macro on).
//  4 Word at 32'h14 == 0 -> pc=0x10 is the last enqueued; state HALT; halted=1 after drain.
//     Then redirect_pc=32'h8 -> RUN, if_pc=8.
//  5 redirect_pc=32'h3FE (MEM_BYTES=1024) -> pc=0x3FC fetched.
//     Next pc 0x400 out of range -> HALT, fetch_fault=1.
//  6 rst asserted mid-stream with if_valid=1
//     -> same cycle if_valid=0, pc=RESET_PC, state IDLE; start required to resume.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, buffers fetched words in a small FIFO for decode,
// applies redirects, stops on zero word / out-of-range PC. Optional perf counters: FETCH_PERF_EN.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned FQ_DEPTH  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_valid,
    output logic [31:0] o_if_instr,
    output logic [31:0] o_if_pc,
    input  logic        i_if_ready,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_halted,
    output logic        o_fetch_fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] o_perf_fetch_cnt,
    output logic [31:0] o_perf_flush_cnt
`endif
);

    localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);
    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_pc;
    logic [CW-1:0] r_count;
    logic [31:0]   r_q_instr [FQ_DEPTH];
    logic [31:0]   r_q_pc    [FQ_DEPTH];
    logic [31:0]   r_out_instr;
    logic [31:0]   r_out_pc;
    logic          r_fault;

    logic [31:0]   w_q_instr [FQ_DEPTH];
    logic [31:0]   w_q_pc    [FQ_DEPTH];
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_wr_idx;
    logic          w_redirect;
    logic          w_fetching;
    logic          w_deq;
    logic          w_slot;
    logic          w_oor;
    logic          w_zero;
    logic          w_enq;
    logic          w_stop;
    logic          w_misalign;

    assign w_redirect = i_redirect_valid && (r_state != S_IDLE);
    // The start cycle itself is a fetch slot, so the first word is visible one cycle after start.
    assign w_fetching = !w_redirect && ((r_state == S_RUN) || ((r_state == S_IDLE) && i_start));
    assign w_deq      = !w_redirect && (r_count != '0) && i_if_ready;
    assign w_slot     = w_fetching && ((r_count < DEPTH_C) || w_deq);
    assign w_oor      = r_pc > LAST_PC;
    assign w_zero     = (i_imem_rdata == 32'h0);
    assign w_enq      = w_slot && !w_oor && !w_zero;
    assign w_stop     = w_slot && (w_oor || w_zero);
    assign w_misalign = w_redirect && (i_redirect_pc[1:0] != 2'b00);
    assign w_wr_idx   = w_deq ? (r_count - 1'b1) : r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = w_stop ? S_HALT : S_RUN;
                end
            end
            S_RUN: begin
                if (w_redirect) begin
                    w_state_nxt = S_RUN;
                end else if (w_stop) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                if (w_redirect) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shift-style queue: entry 0 is always the head.
    always_comb begin
        w_q_instr = r_q_instr;
        w_q_pc    = r_q_pc;
        w_count   = r_count;
        if (w_redirect) begin
            w_count = '0;
        end else begin
            if (w_deq) begin
                for (int i = 0; i < int'(FQ_DEPTH) - 1; i++) begin
                    w_q_instr[i] = r_q_instr[i+1];
                    w_q_pc[i]    = r_q_pc[i+1];
                end
                w_count = r_count - 1'b1;
            end
            if (w_enq) begin
                for (int i = 0; i < int'(FQ_DEPTH); i++) begin
                    if (w_wr_idx == CW'(i)) begin
                        w_q_instr[i] = i_imem_rdata;
                        w_q_pc[i]    = r_pc;
                    end
                end
                w_count = w_wr_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc        <= RESET_PC;
            r_count     <= '0;
            r_out_instr <= 32'h0;
            r_out_pc    <= 32'h0;
            r_fault     <= 1'b0;
            for (int i = 0; i < int'(FQ_DEPTH); i++) begin
                r_q_instr[i] <= 32'h0;
                r_q_pc[i]    <= 32'h0;
            end
        end else begin
            r_count   <= w_count;
            r_q_instr <= w_q_instr;
            r_q_pc    <= w_q_pc;
            if (w_count != '0) begin
                r_out_instr <= w_q_instr[0];
                r_out_pc    <= w_q_pc[0];
            end
            if (w_redirect) begin
                r_pc <= {i_redirect_pc[31:2], 2'b00};
            end else if (w_enq) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_misalign || (w_slot && w_oor)) begin
                r_fault <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_flush;
    logic [32:0] w_flush_sum;

    assign w_flush_sum = {1'b0, r_perf_flush} + 33'(r_count);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_perf_fetch <= 32'h0;
            r_perf_flush <= 32'h0;
        end else begin
            if (w_enq && (r_perf_fetch != 32'hFFFF_FFFF)) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (w_redirect) begin
                r_perf_flush <= w_flush_sum[32] ? 32'hFFFF_FFFF : w_flush_sum[31:0];
            end
        end
    end

    assign o_perf_fetch_cnt = r_perf_fetch;
    assign o_perf_flush_cnt = r_perf_flush;
`endif

    assign o_imem_addr   = r_pc;
    assign o_if_valid    = (r_count != '0);
    assign o_if_instr    = r_out_instr;
    assign o_if_pc       = r_out_pc;
    assign o_halted      = (r_state == S_HALT) && (r_count == '0);
    assign o_fetch_fault = r_fault;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: queue-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instr_fetch_ctrl;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic        fetch_fault;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    logic [31:0] mem [256];

    int n_pass;
    int n_total;

    instr_fetch_ctrl #(
        .RESET_PC (32'h0),
        .MEM_BYTES(1024),
        .FQ_DEPTH (DEPTH)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .o_imem_addr     (imem_addr),
        .i_imem_rdata    (imem_rdata),
        .o_if_valid      (if_valid),
        .o_if_instr      (if_instr),
        .o_if_pc         (if_pc),
        .i_if_ready      (if_ready),
        .i_redirect_valid(redirect_valid),
        .i_redirect_pc   (redirect_pc),
        .o_halted        (halted),
        .o_fetch_fault   (fetch_fault)
`ifdef FETCH_PERF_EN
        ,
        .o_perf_fetch_cnt(perf_fetch_cnt),
        .o_perf_flush_cnt(perf_flush_cnt)
`endif
    );

    // Out-of-range addresses return a nonzero word so only the range check can stop fetch there.
    assign imem_rdata = (imem_addr < 32'd1024) ? mem[imem_addr[9:2]] : 32'hFFFF_FFFF;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    int          m_mode;   // 0 idle, 1 run, 2 halt
    logic [31:0] m_pc;
    ent_t        m_q[$];
    logic [31:0] m_head_instr;
    logic [31:0] m_head_pc;
    logic        m_fault;
    logic [31:0] m_fetch_cnt;
    logic [31:0] m_flush_cnt;

    task automatic model_reset();
        m_mode       = 0;
        m_pc         = 32'h0;
        m_q.delete();
        m_head_instr = 32'h0;
        m_head_pc    = 32'h0;
        m_fault      = 1'b0;
        m_fetch_cnt  = 32'h0;
        m_flush_cnt  = 32'h0;
    endtask

    task automatic model_step();
        bit          deq;
        bit          active;
        bit          slot;
        logic [31:0] word;
        longint      sum;
        if (redirect_valid && m_mode != 0) begin
            sum = longint'(m_flush_cnt) + m_q.size();
            m_flush_cnt = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(sum);
            m_q.delete();
            if (redirect_pc % 4 != 0) m_fault = 1'b1;
            m_pc   = redirect_pc - (redirect_pc % 4);
            m_mode = 1;
            return;
        end
        deq    = (m_q.size() > 0) && if_ready;
        active = (m_mode == 1) || (m_mode == 0 && start);
        if (m_mode == 0 && start) m_mode = 1;
        slot = active && ((m_q.size() < DEPTH) || deq);
        if (deq) void'(m_q.pop_front());
        if (slot) begin
            if (m_pc > 32'd1020) begin
                m_fault = 1'b1;
                m_mode  = 2;
            end else begin
                word = mem[m_pc / 4];
                if (word == 32'h0) begin
                    m_mode = 2;
                end else begin
                    m_q.push_back('{instr: word, pc: m_pc});
                    m_pc = m_pc + 32'd4;
                    if (m_fetch_cnt != 32'hFFFF_FFFF) m_fetch_cnt = m_fetch_cnt + 1;
                end
            end
        end
        if (m_q.size() > 0) begin
            m_head_instr = m_q[0].instr;
            m_head_pc    = m_q[0].pc;
        end
    endtask

    always @(negedge clk) begin
        if (rst) model_reset();
        check("imem_addr", imem_addr, m_pc);
        check("if_valid", 32'(if_valid), 32'(m_q.size() > 0));
        check("if_instr", if_instr, m_head_instr);
        check("if_pc", if_pc, m_head_pc);
        check("halted", 32'(halted), 32'(m_mode == 2 && m_q.size() == 0));
        check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
`ifdef FETCH_PERF_EN
        check("perf_fetch_cnt", perf_fetch_cnt, m_fetch_cnt);
        check("perf_flush_cnt", perf_flush_cnt, m_flush_cnt);
`endif
        if (!rst) model_step();
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        model_reset();
        rst = 1'b1;
        start = 1'b0;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | 32'(i);
        mem[5] = 32'h0;

        repeat (2) tick();
        rst = 1'b0;
        check("rst_valid", 32'(if_valid), 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_fault", 32'(fetch_fault), 32'h0);
        check("rst_if_pc", if_pc, 32'h0);

        // 1: streaming with ready high, halting on the zero word at 0x14
        start = 1'b1;
        if_ready = 1'b1;
        tick();
        start = 1'b0;
        check("t1_valid", 32'(if_valid), 32'h1);
        check("t1_pc0", if_pc, 32'h0);
        check("t1_instr0", if_instr, 32'h1000_0000);
        tick();
        check("t1_pc4", if_pc, 32'h4);
        tick();
        check("t1_pc8", if_pc, 32'h8);
        repeat (2) tick();
        check("t4_last", if_pc, 32'h10);
        tick();
        check("t4_halted", 32'(halted), 32'h1);
        check("t4_pc_hold", imem_addr, 32'h14);
        check("t4_if_pc_hold", if_pc, 32'h10);
        redirect_valid = 1'b1;
        redirect_pc = 32'h8;
        tick();
        redirect_valid = 1'b0;
        check("t4_redir_empty", 32'(if_valid), 32'h0);
        check("t4_redir_halted", 32'(halted), 32'h0);
        tick();
        check("t4_redir_pc", if_pc, 32'h8);
        repeat (4) tick();

        // 2: fill the queue with ready low
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b1;
        if_ready = 1'b0;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("t2_pc_hold", imem_addr, 32'h8);
        check("t2_head", if_pc, 32'h0);
        if_ready = 1'b1;
        tick();
        check("t2_no_loss", if_pc, 32'h4);
        if_ready = 1'b0;
        tick();

        // 3: redirect while full
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("t3_flushed", 32'(if_valid), 32'h0);
        check("t3_addr", imem_addr, 32'h40);
`ifdef FETCH_PERF_EN
        check("t3_flush_cnt", perf_flush_cnt, 32'd2);
`endif
        tick();
        check("t3_target", if_pc, 32'h40);
        if_ready = 1'b1;
        tick();

        // 6: asynchronous reset with a valid head
        check("t6_pre_valid", 32'(if_valid), 32'h1);
        rst = 1'b1;
        #1;
        check("t6_valid", 32'(if_valid), 32'h0);
        check("t6_addr", imem_addr, 32'h0);
        tick();
        rst = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0;
        repeat (2) tick();
        check("t6_idle", 32'(if_valid), 32'h0);
        check("t6_idle_addr", imem_addr, 32'h0);

        // 5: misaligned redirect near the top of memory, then out of range
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_fault_pre", 32'(fetch_fault), 32'h0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h3FE;
        tick();
        redirect_valid = 1'b0;
        check("t5_aligned", imem_addr, 32'h3FC);
        tick();
        check("t5_last", if_pc, 32'h3FC);
        check("t5_next", imem_addr, 32'h400);
        tick();
        check("t5_halted", 32'(halted), 32'h1);
        check("t5_fault", 32'(fetch_fault), 32'h1);

        // randomized traffic
        rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mem[i] = ($urandom_range(0, 11) == 0) ? 32'h0 : ($urandom | 32'h1);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            start          = ($urandom_range(0, 9) == 0);
            if_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 5) == 0)
                redirect_pc = 32'h3F0 + 32'($urandom_range(0, 15));
            else
                redirect_pc = 32'($urandom_range(0, 255)) * 4;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        start = 1'b0;
        redirect_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
